onehot_scanner: RTL
===================

ONEHOT_SCANNER -- requirements
Module: onehot_scanner

Interface
REQ-001 Parameter LENGTH, default 4: number of select lines; legal range 2..64.
REQ-002 Parameter WRAP, default 0: 0 = scan ends at the last line; 1 = scan wraps around to the opposite end.
REQ-003 Parameter IW, default $clog2(LENGTH): index width; not overridden by users.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  load start_idx and begin a scan.
REQ-007 start_idx  input  IW  first selected line.
REQ-008 step  input  1  advance one line.
REQ-009 dir  input  1  step direction: 0 = toward LENGTH-1, 1 = toward 0; sampled on every step.
REQ-010 abort  input  1  terminate the scan without a done pulse.
REQ-011 out_en  input  1  output gate for sel.
REQ-012 sel  output  LENGTH  one-hot select, gated by out_en.
REQ-013 idx  output  IW  binary index of the current line.
REQ-014 busy  output  1  high while in SCAN.
REQ-015 done  output  1  one-cycle pulse when a non-wrapping scan completes.
REQ-016 wrapped  output  1  one-cycle pulse on each wrap-around (WRAP=1 only).

Function
REQ-017 Two states, IDLE and SCAN; all state, idx, one-hot register and pulse flags are registered on clk.
REQ-018 sel = out_en ? onehot_reg : 0, purely combinational; out_en does not affect state.
REQ-019 In IDLE, onehot_reg is all zeros and idx holds its last value.
REQ-020 start=1 in either state: next cycle SCAN, idx = start_idx, onehot_reg = 1 << idx.
REQ-021 start_idx >= LENGTH: clamped to LENGTH-1.
REQ-022 step=1 in SCAN, not at the end line for the current dir: idx moves by +1 (dir=0) or -1 (dir=1); onehot_reg shifts correspondingly the next cycle.
REQ-023 End line: LENGTH-1 for dir=0, 0 for dir=1.
REQ-024 step at the end line, WRAP=0: next cycle IDLE, onehot_reg = 0, done=1 for exactly one cycle.
REQ-025 step at the end line, WRAP=1: idx jumps to the opposite end (0 or LENGTH-1), state stays SCAN, wrapped=1 for exactly one cycle; done never asserts.
REQ-026 step in IDLE: ignored.
REQ-027 Priority, highest first: abort, start, step.
REQ-028 abort=1: next cycle IDLE, onehot_reg = 0, no done or wrapped pulse.
REQ-029 abort and start in the same cycle: abort wins.
REQ-030 Latency is exactly one clock from a qualifying input edge to the sel/idx/busy/done/wrapped change.
REQ-031 In SCAN, onehot_reg shall contain exactly one set bit, equal to 1 << idx, in every cycle.
REQ-032 busy = (state == SCAN).

Reset
REQ-033 reset asserted, regardless of clk: immediately state=IDLE, idx=0, onehot_reg=0, sel=0, busy=0, done=0, wrapped=0.
REQ-034 reset asserted mid-scan: the scan is discarded; no done pulse is produced on release.
REQ-035 After reset deasserts, inputs take effect from the first rising clk edge.

Verification (LENGTH=4 unless noted)
REQ-036 WRAP=0, out_en=1: start with start_idx=0, then 4 steps at dir=0 -> sel 0001, 0010, 0100, 1000; fourth step -> sel=0000, busy=0, done high for one cycle.
REQ-037 WRAP=1: start with start_idx=3, dir=1, 5 steps -> idx 3,2,1,0,3,2; wrapped pulses once on the 0->3 transition; done stays 0.
REQ-038 start_idx=7 with LENGTH=4 -> idx=3, sel=1000; out_en=0 -> sel=0000 while idx and busy are unchanged.
REQ-039 abort, start and step all high together mid-scan -> next cycle IDLE, sel=0, done=0; start alone the next cycle -> SCAN at start_idx.
REQ-040 reset pulse asserted between clock edges while idx=2 -> outputs clear before the next clk edge; after release, step is ignored until a start.
REQ-041 Random start/step/dir/abort for 10k cycles with LENGTH=5, WRAP=1 -> assertion REQ-031 holds, and no done pulse occurs.

Source files
------------

// File: rtl/onehot_scanner.sv
// One-hot line scanner: walks a single active select line up or down on each
// step, either stopping at the end line (done pulse) or wrapping around.
module onehot_scanner #(
    parameter int LENGTH = 4,
    parameter int WRAP   = 0,
    parameter int IW     = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [IW-1:0]     start_idx,
    input  logic              step,
    input  logic              dir,
    input  logic              abort,
    input  logic              out_en,
    output logic [LENGTH-1:0] sel,
    output logic [IW-1:0]     idx,
    output logic              busy,
    output logic              done,
    output logic              wrapped
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(LENGTH - 1);
    localparam bit            WRAP_EN  = (WRAP != 0);

    state_t            state_reg, state_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [LENGTH-1:0] onehot_reg, onehot_next;
    logic              done_reg, done_next;
    logic              wrapped_reg, wrapped_next;
    logic [IW-1:0]     start_clamped;
    logic              at_end;

    // When LENGTH fills the index range no start_idx can overshoot.
    generate
        if (LENGTH == (1 << IW)) begin : g_no_clamp
            assign start_clamped = start_idx;
        end else begin : g_clamp
            assign start_clamped = (start_idx > LAST_IDX) ? LAST_IDX : start_idx;
        end
    endgenerate

    assign at_end = dir ? (idx_reg == '0) : (idx_reg == LAST_IDX);

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        done_next    = 1'b0;
        wrapped_next = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else if (start) begin
            state_next = SCAN;
            idx_next   = start_clamped;
        end else if (step && (state_reg == SCAN)) begin
            if (!at_end) begin
                idx_next = dir ? (idx_reg - 1'b1) : (idx_reg + 1'b1);
            end else if (WRAP_EN) begin
                idx_next     = dir ? LAST_IDX : '0;
                wrapped_next = 1'b1;
            end else begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
        end
    end

    // The one-hot pattern is decoded from the next index so it can never
    // drift from idx; it is all zeros whenever the next state is IDLE.
    generate
        for (genvar gi = 0; gi < LENGTH; gi++) begin : g_decode
            assign onehot_next[gi] = (state_next == SCAN) && (idx_next == IW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            onehot_reg  <= '0;
            done_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            onehot_reg  <= onehot_next;
            done_reg    <= done_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign sel     = out_en ? onehot_reg : '0;
    assign idx     = idx_reg;
    assign busy    = (state_reg == SCAN);
    assign done    = done_reg;
    assign wrapped = wrapped_reg;

endmodule
